codificador_instrucciones: RTL and testbench

Instruction encoder and loader: the inverse of the control unit's opcode decode. It accepts one instruction per handshake as an ALUOP-style class code plus register and immediate fields. It assembles the 32-bit MIPS word and writes it into instruction memory at an auto-incrementing word address. It sits between the testbench or program-loader front end and the instruction memory write port, ahead of the single-cycle datapath.

---
 rtl/codificador_instrucciones.sv | 155 +++++++++++++++
 tb/tb_codificador_instrucciones.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/codificador_instrucciones.sv
// Instruction encoder and loader. Accepts one instruction per handshake as a
// class code plus register and immediate fields. It assembles the 32-bit MIPS
// word and writes it into instruction memory at an auto-incrementing word
// address. The counter saturates at DEPTH (full) and only clr or reset releases it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; in_ready high unless full or in reset
// WRITE | mem_we strobe cycle for the word captured on the accept edge
module codificador_instrucciones #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } stateT;

  localparam logic [ADDR_W:0] depthWords = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] oneWord    = {{ADDR_W{1'b0}}, 1'b1};

  localparam logic [3:0] clsRType = 4'b0010;
  localparam logic [3:0] clsAddi  = 4'b0000;
  localparam logic [3:0] clsOri   = 4'b0001;
  localparam logic [3:0] clsAndi  = 4'b0011;
  localparam logic [3:0] clsLw    = 4'b0100;
  localparam logic [3:0] clsSw    = 4'b0101;
  localparam logic [3:0] clsSlti  = 4'b0110;
  localparam logic [3:0] clsBeq   = 4'b0111;
  localparam logic [3:0] clsBne   = 4'b1000;
  localparam logic [3:0] clsBgtz  = 4'b1001;

  stateT       state;
  stateT       nextState;
  logic        readyInt;
  logic        accept;
  logic        classLegal;
  logic        isRType;
  logic [5:0]  opcode;
  logic [4:0]  rtField;
  logic [31:0] encodedWord;

  // Class code to opcode lookup; anything outside the table is illegal.
  always_comb begin
    opcode     = 6'b000000;
    classLegal = 1'b1;
    isRType    = 1'b0;
    case (in_class)
      clsRType: begin
        opcode  = 6'b000000;
        isRType = 1'b1;
      end
      clsAddi: opcode = 6'b001000;
      clsOri:  opcode = 6'b001101;
      clsAndi: opcode = 6'b001100;
      clsLw:   opcode = 6'b100011;
      clsSw:   opcode = 6'b101011;
      clsSlti: opcode = 6'b001010;
      clsBeq:  opcode = 6'b000100;
      clsBne:  opcode = 6'b000101;
      clsBgtz: opcode = 6'b000111;
      default: classLegal = 1'b0;
    endcase
  end

  // Word assembly; bgtz has no rt operand so that field is forced to zero.
  always_comb begin
    rtField = (in_class == clsBgtz) ? 5'b00000 : in_rt;
    if (isRType) begin
      encodedWord = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
    end else begin
      encodedWord = {opcode, in_rs, rtField, in_imm};
    end
  end

  assign full = (count == depthWords);

  // State register; reset abandons any write in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state, handshake and write strobe.
  always_comb begin
    nextState = state;
    readyInt  = 1'b0;
    accept    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        readyInt = !full && rst_n;
        accept   = in_valid && readyInt;
        if (accept && classLegal) begin
          nextState = WRITE;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign in_ready = readyInt;

  // Captured write address/data, word counter and sticky illegal-class flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      if (accept && classLegal) begin
        // A request accepted on the clr edge lands at the start of the cleared space.
        mem_addr  <= clr ? '0 : count[ADDR_W-1:0];
        mem_wdata <= encodedWord;
      end
      if (clr) begin
        count <= '0;
        err   <= 1'b0;
      end else if (state == WRITE) begin
        count <= count + oneWord;
      end
      if (accept && !classLegal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_codificador_instrucciones.sv
// Directed bench for codificador_instrucciones: instance A uses ADDR_W=8,
// instance B uses ADDR_W=2 for the full/clr scenario. Both share stimulus.
module tb_codificador_instrucciones;

  typedef struct packed {
    logic [3:0]  cls;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] expWord;
  } reqT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_class = 4'd0;
  logic [4:0]  in_rs = 5'd0;
  logic [4:0]  in_rt = 5'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_shamt = 5'd0;
  logic [5:0]  in_funct = 6'd0;
  logic [15:0] in_imm = 16'd0;

  logic        inReadyA, memWeA, fullA, errA;
  logic [7:0]  memAddrA;
  logic [31:0] memWdataA;
  logic [8:0]  countA;

  logic        inReadyB, memWeB, fullB, errB;
  logic [1:0]  memAddrB;
  logic [31:0] memWdataB;
  logic [2:0]  countB;

  int checks = 0;
  int errors = 0;

  codificador_instrucciones #(.ADDR_W(8)) dutA (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(inReadyA),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .mem_we(memWeA), .mem_addr(memAddrA), .mem_wdata(memWdataA),
    .count(countA), .full(fullA), .err(errA)
  );

  codificador_instrucciones #(.ADDR_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(inReadyB),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .mem_we(memWeB), .mem_addr(memAddrB), .mem_wdata(memWdataB),
    .count(countB), .full(fullB), .err(errB)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReq(input reqT r);
    in_class = r.cls;
    in_rs    = r.rs;
    in_rt    = r.rt;
    in_rd    = r.rd;
    in_shamt = r.sh;
    in_funct = r.fn;
    in_imm   = r.imm;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    clr = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (inReadyA !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", inReadyA); end
    checks++; if (memWeA !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", memWeA); end
    checks++; if (memAddrA !== 8'd0) begin errors++; $display("FAIL reset_addr: got %h expected 00", memAddrA); end
    checks++; if (memWdataA !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", memWdataA); end
    checks++; if (countA !== 9'd0 || fullA !== 1'b0 || errA !== 1'b0) begin errors++; $display("FAIL reset_cnt: got count %0d full %b err %b expected 0 0 0", countA, fullA, errA); end
    rst_n = 1'b1;
    #1;
    checks++; if (inReadyA !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", inReadyA); end
  endtask

  task automatic test_encode();
    reqT v [3];
    v[0] = '{4'b0000, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 32'h20080005};
    v[1] = '{4'b0010, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0000, 32'h01095020};
    v[2] = '{4'b0100, 5'd8, 5'd9, 5'd0, 5'd0, 6'h00, 16'h0004, 32'h8D090004};
    for (int i = 0; i < 3; i++) begin
      applyReq(v[i]);
      in_valid = 1'b1;
      checks++; if (inReadyA !== 1'b1) begin errors++; $display("FAIL enc_ready[%0d]: got %b expected 1", i, inReadyA); end
      tick();
      in_valid = 1'b0;
      checks++; if (memWeA !== 1'b1 || inReadyA !== 1'b0) begin errors++; $display("FAIL enc_we[%0d]: got we %b ready %b expected 1 0", i, memWeA, inReadyA); end
      checks++; if (memAddrA !== 8'(i)) begin errors++; $display("FAIL enc_addr[%0d]: got %0d expected %0d", i, memAddrA, i); end
      checks++; if (memWdataA !== v[i].expWord) begin errors++; $display("FAIL enc_wdata[%0d]: got %h expected %h", i, memWdataA, v[i].expWord); end
      tick();
      checks++; if (memWeA !== 1'b0 || countA !== 9'(i + 1)) begin errors++; $display("FAIL enc_count[%0d]: got we %b count %0d expected 0 %0d", i, memWeA, countA, i + 1); end
      checks++; if (memWdataA !== v[i].expWord) begin errors++; $display("FAIL enc_hold[%0d]: got %h expected %h", i, memWdataA, v[i].expWord); end
    end
  endtask

  task automatic test_branches();
    reqT v [2];
    v[0] = '{4'b0111, 5'd8, 5'd9, 5'd0, 5'd0, 6'h00, 16'hFFFE, 32'h1109FFFE};
    v[1] = '{4'b1001, 5'd8, 5'd5, 5'd0, 5'd0, 6'h00, 16'h0003, 32'h1D000003};
    for (int i = 0; i < 2; i++) begin
      applyReq(v[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (memWeA !== 1'b1 || memAddrA !== 8'(3 + i)) begin errors++; $display("FAIL br_addr[%0d]: got we %b addr %0d expected 1 %0d", i, memWeA, memAddrA, 3 + i); end
      checks++; if (memWdataA !== v[i].expWord) begin errors++; $display("FAIL br_wdata[%0d]: got %h expected %h", i, memWdataA, v[i].expWord); end
      tick();
    end
    checks++; if (countA !== 9'd5) begin errors++; $display("FAIL br_count: got %0d expected 5", countA); end
  endtask

  task automatic test_illegal();
    reqT bad, ori;
    bad = '{4'b1100, 5'd1, 5'd2, 5'd3, 5'd0, 6'h00, 16'h1234, 32'h0};
    ori = '{4'b0001, 5'd0, 5'd2, 5'd0, 5'd0, 6'h00, 16'h00FF, 32'h340200FF};
    applyReq(bad);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (memWeA !== 1'b0 || errA !== 1'b1) begin errors++; $display("FAIL ill_err: got we %b err %b expected 0 1", memWeA, errA); end
    checks++; if (inReadyA !== 1'b1 || countA !== 9'd5) begin errors++; $display("FAIL ill_state: got ready %b count %0d expected 1 5", inReadyA, countA); end
    tick();
    checks++; if (memWeA !== 1'b0 || countA !== 9'd5) begin errors++; $display("FAIL ill_nowrite: got we %b count %0d expected 0 5", memWeA, countA); end
    applyReq(ori);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (memWeA !== 1'b1 || memAddrA !== 8'd5 || memWdataA !== ori.expWord) begin errors++; $display("FAIL ill_ori: got we %b addr %0d data %h expected 1 5 %h", memWeA, memAddrA, memWdataA, ori.expWord); end
    tick();
    checks++; if (countA !== 9'd6 || errA !== 1'b1) begin errors++; $display("FAIL ill_after: got count %0d err %b expected 6 1", countA, errA); end
  endtask

  task automatic test_full();
    reqT v [5];
    v[0] = '{4'b0011, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h00F0, 32'h302200F0};
    v[1] = '{4'b0110, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'h8000, 32'h28648000};
    v[2] = '{4'b1000, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0001, 32'h14220001};
    v[3] = '{4'b0101, 5'd29, 5'd31, 5'd0, 5'd0, 6'h00, 16'h0010, 32'hAFBF0010};
    v[4] = '{4'b0000, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 32'h20080005};
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyReq(v[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (memWeB !== 1'b1 || memAddrB !== 2'(i) || memWdataB !== v[i].expWord) begin errors++; $display("FAIL full_wr[%0d]: got we %b addr %0d data %h expected 1 %0d %h", i, memWeB, memAddrB, memWdataB, i, v[i].expWord); end
      tick();
    end
    checks++; if (fullB !== 1'b1 || inReadyB !== 1'b0 || countB !== 3'd4) begin errors++; $display("FAIL full_flag: got full %b ready %b count %0d expected 1 0 4", fullB, inReadyB, countB); end
    applyReq(v[4]);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (memWeB !== 1'b0 || countB !== 3'd4) begin errors++; $display("FAIL full_block[%0d]: got we %b count %0d expected 0 4", i, memWeB, countB); end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (countB !== 3'd0 || fullB !== 1'b0 || inReadyB !== 1'b1 || memWeB !== 1'b0) begin errors++; $display("FAIL full_clr: got count %0d full %b ready %b we %b expected 0 0 1 0", countB, fullB, inReadyB, memWeB); end
    tick();
    in_valid = 1'b0;
    checks++; if (memWeB !== 1'b1 || memAddrB !== 2'd0 || memWdataB !== v[4].expWord) begin errors++; $display("FAIL full_fifth: got we %b addr %0d data %h expected 1 0 %h", memWeB, memAddrB, memWdataB, v[4].expWord); end
    tick();
    checks++; if (countB !== 3'd1 || memWeB !== 1'b0) begin errors++; $display("FAIL full_fifth_cnt: got count %0d we %b expected 1 0", countB, memWeB); end
  endtask

  task automatic test_back_to_back();
    reqT v [3];
    v[0] = '{4'b0000, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 32'h20080005};
    v[1] = '{4'b0010, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0000, 32'h01095020};
    v[2] = '{4'b0100, 5'd8, 5'd9, 5'd0, 5'd0, 6'h00, 16'h0004, 32'h8D090004};
    doReset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyReq(v[i]);
      checks++; if (inReadyA !== 1'b1 || memWeA !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d]: got ready %b we %b expected 1 0", i, inReadyA, memWeA); end
      tick();
      if (i == 2) in_valid = 1'b0;
      checks++; if (memWeA !== 1'b1 || inReadyA !== 1'b0 || memAddrA !== 8'(i) || memWdataA !== v[i].expWord) begin errors++; $display("FAIL b2b_wr[%0d]: got we %b ready %b addr %0d data %h expected 1 0 %0d %h", i, memWeA, inReadyA, memAddrA, memWdataA, i, v[i].expWord); end
      tick();
      checks++; if (countA !== 9'(i + 1)) begin errors++; $display("FAIL b2b_cnt[%0d]: got %0d expected %0d", i, countA, i + 1); end
    end
    tick();
    checks++; if (memWeA !== 1'b0 || countA !== 9'd3) begin errors++; $display("FAIL b2b_end: got we %b count %0d expected 0 3", memWeA, countA); end
  endtask

  task automatic test_reset_mid();
    reqT r;
    r = '{4'b0001, 5'd0, 5'd2, 5'd0, 5'd0, 6'h00, 16'h00FF, 32'h340200FF};
    applyReq(r);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (memWeA !== 1'b1) begin errors++; $display("FAIL rstmid_we: got %b expected 1", memWeA); end
    rst_n = 1'b0;
    tick();
    checks++; if (memWeA !== 1'b0 || countA !== 9'd0 || memWdataA !== 32'd0 || inReadyA !== 1'b0) begin errors++; $display("FAIL rstmid_clear: got we %b count %0d data %h ready %b expected 0 0 0 0", memWeA, countA, memWdataA, inReadyA); end
    rst_n = 1'b1;
    #1;
    checks++; if (inReadyA !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", inReadyA); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_branches();
    test_illegal();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
